imem_loader: RTL and testbench

Serial boot loader that writes program words into the core's instruction memory. It is the write side of the instruction-fetch read port. It consumes a byte stream from an external receiver and assembles it into little-endian 32-bit words. It writes those words to consecutive word addresses and holds the pipeline in PC reset until a complete, valid image has been loaded.

---
 rtl/imem_loader.sv | 199 +++++++++++++++++++
 tb/tb_imem_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: serial boot loader that assembles little-endian words from a byte stream into
// instruction memory and holds the core in PC reset until a frame completes. Checksum: LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [32:0] CAP  = 33'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_e;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e S_END = S_CHECK;
`else
  localparam state_e S_END = S_DONE;
`endif

  state_e              state_q, state_d;
  logic                rx_ready_q, rx_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                core_hold_q, core_hold_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
  logic [15:0]         words_q, words_d;
  logic [7:0]          cnt_lo_q, cnt_lo_d;
  logic [15:0]         n_q, n_d;
  logic [15:0]         widx_q, widx_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         word_q, word_d;
  logic [TO_W-1:0]     idle_q, idle_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic        accept_c, sync_start_c, timed_c, timeout_c, last_word_c;
  logic [15:0] n_c;

  assign accept_c     = rx_valid && rx_ready_q;
  assign sync_start_c = accept_c && (rx_data == 8'hA5) && (state_q == S_IDLE || state_q == S_DONE);
  assign timed_c      = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
  assign timeout_c    = (TIMEOUT_CYCLES != 0) && timed_c && !accept_c &&
                        (idle_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign n_c          = {rx_data, cnt_lo_q};
  assign last_word_c  = (widx_q + 16'd1) == n_q;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rx_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      words_q      <= '0;
      cnt_lo_q     <= '0;
      n_q          <= '0;
      widx_q       <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      idle_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_hold_q  <= core_hold_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      words_q      <= words_d;
      cnt_lo_q     <= cnt_lo_d;
      n_q          <= n_d;
      widx_q       <= widx_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      idle_q       <= idle_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // Next-state logic; an idle timeout overrides everything in the framed states
  always_comb begin
    state_d = state_q;
    if (timeout_c) begin
      state_d = S_ERROR;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (sync_start_c) state_d = S_CNT_LO;
        S_CNT_LO:       if (accept_c) state_d = S_CNT_HI;
        S_CNT_HI: begin
          if (accept_c) begin
            if (33'(n_c) > CAP)     state_d = S_ERROR;
            else if (n_c == 16'd0)  state_d = S_END;
            else                    state_d = S_DATA;
          end
        end
        S_DATA:         if (accept_c && lane_q == 2'd3 && last_word_c) state_d = S_END;
`ifdef LOADER_CHECKSUM_EN
        S_CHECK:        if (accept_c) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
`endif
        S_ERROR:        state_d = S_IDLE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    words_d      = words_q;
    cnt_lo_d     = cnt_lo_q;
    n_d          = n_q;
    widx_d       = widx_q;
    lane_d       = lane_q;
    word_d       = word_q;
    idle_d       = (accept_c || !timed_c) ? '0 : idle_q + TO_W'(1);
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    if (imem_we_q) words_d = words_q + 16'd1;

    if (sync_start_c) begin
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
      words_d     = '0;
      widx_d      = '0;
      lane_d      = '0;
`ifdef LOADER_CHECKSUM_EN
      csum_d      = '0;
`endif
    end

    if (accept_c && state_q == S_CNT_LO) cnt_lo_d = rx_data;
    if (accept_c && state_q == S_CNT_HI) n_d = n_c;

    // Bytes shift in from the top so the 4th byte completes a little-endian word
    if (accept_c && state_q == S_DATA) begin
      word_d = {rx_data, word_q[23:8]};
      lane_d = lane_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
      csum_d = csum_q ^ rx_data;
`endif
      if (lane_q == 2'd3) begin
        imem_we_d    = 1'b1;
        imem_addr_d  = ADDR_W'(widx_q);
        imem_wdata_d = {rx_data, word_q};
        widx_d       = widx_q + 16'd1;
      end
    end

    if (state_d == S_DONE && state_q != S_DONE) load_done_d = 1'b1;
    if (state_d == S_ERROR) load_err_d = 1'b1;
  end

  assign core_hold_d = (state_d != S_DONE);
  assign rx_ready_d  = (state_d != S_ERROR) && !imem_we_d;

  assign rx_ready     = rx_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_hold    = core_hold_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loading, error paths, timeout, write spacing and async reset.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TMO    = 50;

  typedef logic [7:0] bytes_t[$];

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;
  logic [15:0]       words_loaded;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int base;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  bytes_t      fr;

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (imem_we === 1'b1) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after the byte was accepted
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) check("ready_wait", 32'(rx_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_bytes(input bytes_t b);
    foreach (b[i]) send_byte(b[i]);
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_hold"},  32'(core_hold),    32'd1);
    check({pfx, "_ready"}, 32'(rx_ready),     32'd1);
    check({pfx, "_we"},    32'(imem_we),      32'd0);
    check({pfx, "_addr"},  32'(imem_addr),    32'd0);
    check({pfx, "_wdata"}, imem_wdata,        32'd0);
    check({pfx, "_done"},  32'(load_done),    32'd0);
    check({pfx, "_err"},   32'(load_err),     32'd0);
    check({pfx, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;

    // Idle: nothing happens for 1000 cycles
    repeat (1000) @(negedge clk);
    #1;
    check("idle_writes", 32'(wr_addr.size()), 32'd0);
    check("idle_hold",   32'(core_hold),      32'd1);
    check("idle_done",   32'(load_done),      32'd0);

    // Good two-word frame with continuous rx_valid
    base = wr_addr.size();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    fr.push_back(8'h90);
`endif
    send_bytes(fr);
    #1;
    check("good_done", 32'(load_done), 32'd1);
    check("good_hold", 32'(core_hold), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("good_words",  32'(words_loaded),          32'd2);
    check("good_nwrite", 32'(wr_addr.size() - base), 32'd2);
    if (wr_addr.size() >= base + 2) begin
      check("good_a0",    wr_addr[base],                     32'd0);
      check("good_d0",    wr_data[base],                     32'h0000_0013);
      check("good_a1",    wr_addr[base+1],                   32'd1);
      check("good_d1",    wr_data[base+1],                   32'h0010_0093);
      check("we_spacing", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd5);
    end

    // Empty frame restarts from DONE
    base = wr_addr.size();
    fr = '{8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    fr.push_back(8'h00);
`endif
    send_bytes(fr);
    #1;
    check("empty_done", 32'(load_done), 32'd1);
    check("empty_hold", 32'(core_hold), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("empty_words",  32'(words_loaded),          32'd0);
    check("empty_nwrite", 32'(wr_addr.size() - base), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: words land, frame flagged
    base = wr_addr.size();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h84};
    send_bytes(fr);
    #1;
    check("badcs_err",  32'(load_err),  32'd1);
    check("badcs_hold", 32'(core_hold), 32'd1);
    check("badcs_done", 32'(load_done), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("badcs_nwrite", 32'(wr_addr.size() - base), 32'd2);
    check("badcs_words",  32'(words_loaded),          32'd2);
`endif

    // Oversized count: 257 words into a 256-word memory
    base = wr_addr.size();
    fr = '{8'hA5, 8'h01, 8'h01};
    send_bytes(fr);
    #1;
    check("big_err",   32'(load_err),  32'd1);
    check("big_hold",  32'(core_hold), 32'd1);
    check("big_ready", 32'(rx_ready),  32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("big_nwrite",   32'(wr_addr.size() - base), 32'd0);
    check("big_ready_ok", 32'(rx_ready),              32'd1);

    // Timeout 50 cycles after the last accepted byte
    fr = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_bytes(fr);
    repeat (49) @(negedge clk);
    #1;
    check("tmo_early", 32'(load_err), 32'd0);
    @(negedge clk);
    #1;
    check("tmo_err",   32'(load_err),     32'd1);
    check("tmo_words", 32'(words_loaded), 32'd0);
    check("tmo_hold",  32'(core_hold),    32'd1);

    // 0xA5 inside DATA is payload, not resync
    base = wr_addr.size();
    fr = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
`ifdef LOADER_CHECKSUM_EN
    fr.push_back(8'h00);
`endif
    send_bytes(fr);
    repeat (2) @(negedge clk);
    #1;
    check("a5_done",   32'(load_done),    32'd1);
    check("a5_words",  32'(words_loaded), 32'd1);
    if (wr_data.size() > base) check("a5_data", wr_data[base], 32'hA5A5_A5A5);
    else check("a5_nwrite", 32'(wr_data.size() - base), 32'd1);

    // Asynchronous reset in the middle of DATA
    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_bytes(fr);
    #1;
    check("mid_words", 32'(words_loaded), 32'd1);
    check("mid_wdata", imem_wdata,        32'h4433_2211);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Recovery frame after reset
    base = wr_addr.size();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef LOADER_CHECKSUM_EN
    fr.push_back(8'h08);
`endif
    send_bytes(fr);
    repeat (2) @(negedge clk);
    #1;
    check("rec_done", 32'(load_done), 32'd1);
    if (wr_data.size() > base) begin
      check("rec_addr", wr_addr[base], 32'd0);
      check("rec_data", wr_data[base], 32'h1234_5678);
    end else check("rec_nwrite", 32'(wr_data.size() - base), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
